// File: rtl/seq_pkg.sv
// Shared definitions for the serial feeder and the downstream sequence detector.
// The state encoding is fixed so both blocks can decode it consistently.
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    PAUSE = 2'b10
  } seq_state_e;

  localparam int DEFAULT_DATA_W = 8;

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out shift register with its bit counter.
// dout is always the bit currently presented; cnt is that bit's position in send order.
module piso_shift_reg #(
  parameter int DATA_W    = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              shift,
  input  logic              clear,
  input  logic [DATA_W-1:0] data,
  output logic              dout,
  output logic              last
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_W - 1);

  logic [DATA_W-1:0] sr;
  logic [CNT_W-1:0]  cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of block ordering in simulation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr  <= '0;
      cnt <= '0;
    end else if (clear) begin
      sr  <= '0;
      cnt <= '0;
    end else if (load) begin
      sr  <= data;
      cnt <= '0;
    end else if (shift && (cnt != LAST_IDX)) begin
      // Vacated positions fill with 0 so the register drains to all-zero.
      sr  <= MSB_FIRST ? {sr[DATA_W-2:0], 1'b0} : {1'b0, sr[DATA_W-1:1]};
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign dout = MSB_FIRST ? sr[DATA_W-1] : sr[0];
  assign last = (cnt == LAST_IDX);

endmodule

// File: rtl/serial_bit_feeder.sv
// Serializes parallel words onto a 1-bit stream for the sequence detector.
// Valid/ready upstream, en-based stall downstream; a word loaded on a transfer shows bit 0 next cycle.
module serial_bit_feeder
  import seq_pkg::*;
#(
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              en,
  output logic              dout,
  output logic              dout_valid,
  output logic              frame_end,
  output logic              busy
);

  seq_state_e state, state_nxt;
  logic load, shift, clear, last, transfer;

  piso_shift_reg #(
    .DATA_W   (DATA_W),
    .MSB_FIRST(MSB_FIRST)
  ) u_piso (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .shift(shift),
    .clear(clear),
    .data (in_data),
    .dout (dout),
    .last (last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Ready is forced low during reset so nothing upstream sees a phantom accept.
  always_comb begin
    in_ready = 1'b0;
    if (rst) in_ready = (state == IDLE) || ((state == SHIFT) && last && en);
  end

  assign transfer = in_valid && in_ready;

  // NOTE: every combinational output gets a default before the case so no
  // branch can leave a value unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    shift     = 1'b0;
    clear     = 1'b0;
    case (state)
      IDLE: begin
        if (transfer) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (!en) begin
          state_nxt = PAUSE;
        end else if (!last) begin
          shift = 1'b1;
        end else if (transfer) begin
          load = 1'b1;
        end else begin
          clear     = 1'b1;
          state_nxt = IDLE;
        end
      end
      PAUSE: begin
        // A stall on the final bit has nothing left to resume, so it drains to IDLE.
        if (en) begin
          if (last) begin
            clear     = 1'b1;
            state_nxt = IDLE;
          end else begin
            shift     = 1'b1;
            state_nxt = SHIFT;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign dout_valid = (state == SHIFT);
  assign frame_end  = (state == SHIFT) && last;
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Bench for serial_bit_feeder: an MSB-first and an LSB-first instance, each
// checked against a queue of expected {bit, frame_end} pairs.
module tb_serial_bit_feeder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] m_data, l_data;
  logic         m_valid, l_valid, m_en, l_en;
  logic         m_ready, l_ready, m_dout, l_dout, m_dv, l_dv, m_fe, l_fe, m_busy, l_busy;

  int n_checks = 0;
  int n_fail   = 0;
  int valid_cnt;

  logic [1:0] m_q[$];
  logic [1:0] l_q[$];

  always #5 clk = ~clk;

  serial_bit_feeder #(.DATA_W(W), .MSB_FIRST(1'b1)) u_msb (
    .clk       (clk),
    .rst       (rst),
    .in_data   (m_data),
    .in_valid  (m_valid),
    .in_ready  (m_ready),
    .en        (m_en),
    .dout      (m_dout),
    .dout_valid(m_dv),
    .frame_end (m_fe),
    .busy      (m_busy)
  );

  serial_bit_feeder #(.DATA_W(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk       (clk),
    .rst       (rst),
    .in_data   (l_data),
    .in_valid  (l_valid),
    .in_ready  (l_ready),
    .en        (l_en),
    .dout      (l_dout),
    .dout_valid(l_dv),
    .frame_end (l_fe),
    .busy      (l_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Push the expected serial stream of one word, in send order.
  task automatic expect_word(input logic [W-1:0] w, input bit lsb_inst);
    logic       b;
    logic [1:0] e;
    for (int i = 0; i < W; i++) begin
      b = lsb_inst ? w[i] : w[W-1-i];
      e = {b, (i == W - 1)};
      if (lsb_inst) l_q.push_back(e);
      else          m_q.push_back(e);
    end
  endtask

  always @(negedge clk) begin : monitor
    logic [1:0] e;
    if (m_dv) begin
      check("m_sb_nonempty", (m_q.size() != 0), 1);
      if (m_q.size() != 0) begin
        e = m_q.pop_front();
        check("m_dout", m_dout, e[1]);
        check("m_frame_end", m_fe, e[0]);
      end
    end else begin
      check("m_fe_invalid", m_fe, 0);
      if (!m_busy) check("m_dout_idle", m_dout, 0);
    end
    if (l_dv) begin
      check("l_sb_nonempty", (l_q.size() != 0), 1);
      if (l_q.size() != 0) begin
        e = l_q.pop_front();
        check("l_dout", l_dout, e[1]);
        check("l_frame_end", l_fe, e[0]);
      end
    end else begin
      check("l_fe_invalid", l_fe, 0);
      if (!l_busy) check("l_dout_idle", l_dout, 0);
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    m_data = '0; l_data = '0;
    m_valid = 1'b0; l_valid = 1'b0;
    m_en = 1'b1; l_en = 1'b1;
    #2 rst = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_m_dout", m_dout, 0);
    check("rst_m_dv", m_dv, 0);
    check("rst_m_fe", m_fe, 0);
    check("rst_m_busy", m_busy, 0);
    check("rst_m_ready", m_ready, 0);
    check("rst_l_ready", l_ready, 0);
    #2 rst = 1'b1;
    #1 check("idle_m_ready", m_ready, 1);

    // 0xB5 MSB first, with latency and in_ready per bit
    @(posedge clk); #1;
    m_data = 8'hB5; m_valid = 1'b1; expect_word(8'hB5, 1'b0);
    #1 check("b5_ready_idle", m_ready, 1);
    @(posedge clk); #1 m_valid = 1'b0;
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      check("b5_valid", m_dv, 1);
      check("b5_ready", m_ready, (i == W - 1));
    end
    @(negedge clk);
    check("b5_idle_busy", m_busy, 0);
    check("b5_idle_dv", m_dv, 0);

    // 0xB5 LSB first
    @(posedge clk); #1;
    l_data = 8'hB5; l_valid = 1'b1; expect_word(8'hB5, 1'b1);
    #1 check("lsb_ready_idle", l_ready, 1);
    @(posedge clk); #1 l_valid = 1'b0;
    @(negedge clk) check("lsb_latency", l_dv, 1);
    repeat (W) @(negedge clk);
    check("lsb_idle_busy", l_busy, 0);

    // Back-to-back 0xFF then 0x00; 0x00 is held on the bus until accepted
    @(posedge clk); #1;
    m_data = 8'hFF; m_valid = 1'b1;
    expect_word(8'hFF, 1'b0);
    expect_word(8'h00, 1'b0);
    #1 check("b2b_ready_first", m_ready, 1);
    @(posedge clk); #1 m_data = 8'h00;
    valid_cnt = 0;
    for (int i = 0; i < 2 * W; i++) begin
      @(negedge clk);
      if (m_dv) valid_cnt++;
      check("b2b_ready", m_ready, ((i % W) == W - 1));
      check("b2b_busy", m_busy, 1);
      if (i == W - 1) begin
        @(posedge clk); #1 m_valid = 1'b0;
      end
    end
    check("b2b_contiguous", valid_cnt, 2 * W);
    @(negedge clk) check("b2b_idle_busy", m_busy, 0);

    // Stall for 3 cycles after bit 3 of 0xB5
    @(posedge clk); #1;
    m_data = 8'hB5; m_valid = 1'b1; expect_word(8'hB5, 1'b0);
    @(posedge clk); #1 m_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 m_en = 1'b0;
    @(negedge clk) check("stall_bit3_valid", m_dv, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_dv", m_dv, 0);
      check("stall_hold", m_dout, 1);
      check("stall_busy", m_busy, 1);
      check("stall_ready", m_ready, 0);
    end
    m_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk) check("resume_valid", m_dv, 1);
    end
    @(negedge clk) check("stall_idle_busy", m_busy, 0);

    // Asynchronous reset during bit 5, then 0x0F straight after release
    @(posedge clk); #1;
    m_data = 8'hB5; m_valid = 1'b1; expect_word(8'hB5, 1'b0);
    @(posedge clk); #1 m_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst_dout", m_dout, 0);
    check("arst_dv", m_dv, 0);
    check("arst_fe", m_fe, 0);
    check("arst_busy", m_busy, 0);
    check("arst_ready", m_ready, 0);
    check("arst_discard", m_q.size(), 3);
    m_q.delete();
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    m_data = 8'h0F; m_valid = 1'b1; expect_word(8'h0F, 1'b0);
    check("post_rst_ready", m_ready, 1);
    @(posedge clk); #1 m_valid = 1'b0;
    @(negedge clk) check("post_rst_latency", m_dv, 1);
    repeat (W) @(negedge clk);
    check("post_rst_idle", m_busy, 0);

    check("m_sb_drained", m_q.size(), 0);
    check("l_sb_drained", l_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
